// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester single-port RAM arbiter: FSM encoding
// and default address/data widths.
package ram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way grant picker: one-hot winner from the request vector and the last winner.
// RAM_ARB_FIXED_PRIO_EN: req0 always wins contention and the last-winner input is ignored.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic [1:0] o_win
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic w_unused_last_gnt;
  assign w_unused_last_gnt = i_last_gnt;

  always_comb begin
    o_win = 2'b00;
    if (i_req[0])      o_win = 2'b01;
    else if (i_req[1]) o_win = 2'b10;
  end
`else
  // On contention the requester that did not win last time goes next.
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = i_last_gnt ? 2'b01 : 2'b10;
      default: o_win = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters, one access in flight; write = grant + 1 edge,
// read data 2 cycles after grant. Requesters hold req until gnt. Picker policy: RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   ram_Address,
  output logic [DW-1:0]   ram_WriteData,
  output logic            ram_WriteEn,
  output logic            ram_ReadEn,
  input  logic [DW-1:0]   ram_ReadData
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_gnt;
  logic [1:0]    w_gnt_nxt;
  logic [1:0]    r_rvalid;
  logic [1:0]    w_rvalid_nxt;
  logic          r_we;
  logic          w_we_nxt;
  logic          r_re;
  logic          w_re_nxt;
  logic          r_last_gnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_load_cmd;
  logic          w_load_rdata;
  logic [1:0]    w_win;
  logic          w_idx;
  logic          w_win_we;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  ram_arb_rr u_rr (
    .i_req      (req),
    .i_last_gnt (r_last_gnt),
    .o_win      (w_win)
  );

  assign w_idx       = w_win[1];
  assign w_win_we    = w_idx ? we[1] : we[0];
  assign w_win_addr  = w_idx ? addr[2*AW-1:AW]   : addr[AW-1:0];
  assign w_win_wdata = w_idx ? wdata[2*DW-1:DW]  : wdata[DW-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = 2'b00;
    w_rvalid_nxt = 2'b00;
    w_we_nxt     = 1'b0;
    w_re_nxt     = 1'b0;
    w_load_cmd   = 1'b0;
    w_load_rdata = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = CMD;
          w_load_cmd  = 1'b1;
          w_gnt_nxt   = w_win;
          w_we_nxt    = w_win_we;
          w_re_nxt    = ~w_win_we;
        end
      end
      // The RAM samples the command on the edge that leaves CMD.
      CMD: w_state_nxt = r_re ? RESP : IDLE;
      RESP: begin
        w_state_nxt  = IDLE;
        w_load_rdata = 1'b1;
        w_rvalid_nxt = r_last_gnt ? 2'b10 : 2'b01;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_we     <= w_we_nxt;
      r_re     <= w_re_nxt;
    end
  end

  // Address/data hold between accesses; last winner doubles as the in-flight owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      if (w_load_cmd) begin
        r_addr     <= w_win_addr;
        r_wdata    <= w_win_wdata;
        r_last_gnt <= w_idx;
      end
      if (w_load_rdata) r_rdata <= ram_ReadData;
    end
  end

  assign gnt           = r_gnt;
  assign rvalid        = r_rvalid;
  assign rdata         = r_rdata;
  assign ram_Address   = r_addr;
  assign ram_WriteData = r_wdata;
  assign ram_WriteEn   = r_we;
  assign ram_ReadEn    = r_re;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios, then random traffic checked every cycle
// against a transaction-level model (countdowns plus a model memory).
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req = '0;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_Address;
  logic [DW-1:0]   ram_WriteData;
  logic            ram_WriteEn;
  logic            ram_ReadEn;
  logic [DW-1:0]   ram_ReadData = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .ram_Address   (ram_Address),
    .ram_WriteData (ram_WriteData),
    .ram_WriteEn   (ram_WriteEn),
    .ram_ReadEn    (ram_ReadEn),
    .ram_ReadData  (ram_ReadData)
  );

  // Single-port RAM: read data appears the cycle after ReadEn is sampled.
  logic [DW-1:0] ram_mem [int];
  always @(posedge clk) begin
    if (ram_WriteEn) ram_mem[int'(ram_Address)] = ram_WriteData;
    if (ram_ReadEn)
      ram_ReadData <= ram_mem.exists(int'(ram_Address)) ? ram_mem[int'(ram_Address)] : '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: transaction view of the arbiter.
  logic [1:0]    m_gnt, m_rv, rv_who;
  logic          m_we, m_re;
  logic [AW-1:0] m_addr, pw_a;
  logic [DW-1:0] m_wd, m_rdata, rv_data, pw_d;
  bit            m_last, pw_vld;
  int            busy, rv_cnt;
  logic [DW-1:0] m_mem [int];

  always @(posedge clk or posedge rst) begin : model
    int w;
    logic [AW-1:0] a;
    if (rst) begin
      m_gnt = '0; m_rv = '0; m_we = 1'b0; m_re = 1'b0;
      m_addr = '0; m_wd = '0; m_rdata = '0;
      m_last = 1'b1; busy = 0; rv_cnt = 0; pw_vld = 1'b0;
    end else begin
      if (pw_vld) begin
        m_mem[int'(pw_a)] = pw_d;
        pw_vld = 1'b0;
      end
      m_gnt = '0; m_we = 1'b0; m_re = 1'b0; m_rv = '0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          m_rv    = rv_who;
          m_rdata = rv_data;
        end
      end
      if (busy > 0) busy--;
      else if (req != 2'b00) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w = req[0] ? 0 : 1;
`else
        w = (req == 2'b11) ? (m_last ? 0 : 1) : (req[0] ? 0 : 1);
`endif
        m_last = (w == 1);
        a      = (w == 1) ? addr[2*AW-1:AW] : addr[AW-1:0];
        m_addr = a;
        m_wd   = (w == 1) ? wdata[2*DW-1:DW] : wdata[DW-1:0];
        m_gnt  = (w == 1) ? 2'b10 : 2'b01;
        if (we[w]) begin
          m_we = 1'b1; busy = 1;
          pw_vld = 1'b1; pw_a = a; pw_d = m_wd;
        end else begin
          m_re = 1'b1; busy = 2; rv_cnt = 2; rv_who = m_gnt;
          rv_data = m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("gnt", gnt, m_gnt);
      chk("rvalid", rvalid, m_rv);
      if (m_rv != 2'b00) chk("rdata", rdata, m_rdata);
      chk("ram_WriteEn", ram_WriteEn, m_we);
      chk("ram_ReadEn", ram_ReadEn, m_re);
      chk("ram_Address", ram_Address, m_addr);
      chk("ram_WriteData", ram_WriteData, m_wd);
      chk("en_exclusive", ram_WriteEn & ram_ReadEn, 0);
      chk("gnt_rvalid_same", gnt & rvalid, 0);
    end
  end

  task automatic wait_for(input logic [1:0] mask, input bit on_rv, input string nm);
    int k;
    for (k = 0; k < 20; k++) begin
      if (((on_rv ? rvalid : gnt) & mask) != 2'b00) break;
      @(negedge clk);
    end
    if (k == 20) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting, got none expected %0b", nm, mask);
    end
  endtask

  initial begin
    logic [1:0] seq [4];
    int ng;
    int cnt;

    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_we", ram_WriteEn, 0);
    chk("rst_re", ram_ReadEn, 0);
    chk("rst_addr", ram_Address, 0);
    chk("rst_wdata", ram_WriteData, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;

    // 1: single write
    req = 2'b01; we = 2'b01; addr[AW-1:0] = 10'd131; wdata[DW-1:0] = 8'd39;
    @(negedge clk);
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_we", ram_WriteEn, 1);
    chk("t1_addr", ram_Address, 131);
    chk("t1_wdata", ram_WriteData, 39);
    req = 2'b00;
    @(negedge clk);
    chk("t1_gnt_drop", gnt, 0);
    chk("t1_we_drop", ram_WriteEn, 0);
    chk("t1_addr_hold", ram_Address, 131);

    // 2: read back
    req = 2'b01; we = 2'b00;
    @(negedge clk);
    chk("t2_gnt", gnt, 2'b01);
    chk("t2_re", ram_ReadEn, 1);
    req = 2'b00;
    @(negedge clk);
    chk("t2_rv_early", rvalid, 0);
    @(negedge clk);
    chk("t2_rvalid", rvalid, 2'b01);
    chk("t2_rdata", rdata, 39);

    // 3: sustained contention from a fresh reset
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 2'b11; we = 2'b11; addr = {10'd10, 10'd21}; wdata = {8'd95, 8'd84};
    ng = 0;
    for (int k = 0; k < 4; k++) seq[k] = 2'b00;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin seq[ng] = gnt; ng++; end
    end
    req = 2'b00;
    chk("t3_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk($sformatf("t3_gnt%0d", k), seq[k], 2'b01);
`else
      chk($sformatf("t3_gnt%0d", k), seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
    @(negedge clk);

    // 4: req1 reads addr 21 while req0 writes
    req = 2'b11; we = 2'b01; addr = {10'd21, 10'd5}; wdata = {8'd0, 8'd7};
    wait_for(2'b01, 1'b0, "t4_gnt0");
    req[0] = 1'b0;
    wait_for(2'b10, 1'b0, "t4_gnt1");
    req = 2'b00;
    wait_for(2'b11, 1'b1, "t4_rv");
    chk("t4_rvalid", rvalid, 2'b10);
    chk("t4_rdata", rdata, 84);
    @(negedge clk);

    // 5a: reset while a write command is on the RAM port
    req = 2'b01; we = 2'b01; addr[AW-1:0] = 10'd21; wdata[DW-1:0] = 8'hAA;
    wait_for(2'b01, 1'b0, "t5a_gnt");
    req = 2'b00; rst = 1'b1;
    #1;
    chk("t5_we_async", ram_WriteEn, 0);
    chk("t5_gnt_async", gnt, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 5b: reset during RESP
    req = 2'b01; we = 2'b00; addr[AW-1:0] = 10'd21;
    wait_for(2'b01, 1'b0, "t5b_gnt");
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rv_async", rvalid, 0);
    chk("t5_re_async", ram_ReadEn, 0);
    chk("t5_we_async2", ram_WriteEn, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rv_in_rst", rvalid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rv_after", rvalid, 0);
    req = 2'b11; we = 2'b11; addr = {10'd31, 10'd30}; wdata = {8'd2, 8'd1};
    @(negedge clk);
    chk("t5_first_gnt", gnt, 2'b01);
    req = 2'b10; we = 2'b00; addr[2*AW-1:AW] = 10'd21;
    wait_for(2'b10, 1'b0, "t5c_gnt");
    req = 2'b00;
    wait_for(2'b11, 1'b1, "t5c_rv");
    chk("t5_keep_rv", rvalid, 2'b10);
    chk("t5_keep_rdata", rdata, 84);
    @(negedge clk);

    // 6: req pulse confined to CMD/RESP
    req = 2'b01; we = 2'b00; addr[AW-1:0] = 10'd10;
    wait_for(2'b01, 1'b0, "t6_gnt");
    req = 2'b10; we = 2'b11;
    @(negedge clk);
    @(negedge clk);
    req = 2'b00;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) cnt++;
    end
    chk("t6_no_gnt", cnt, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || gnt[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            we[i]  = 1'($urandom_range(0, 1));
            addr[i*AW +: AW]  = AW'($urandom_range(0, 31));
            wdata[i*DW +: DW] = DW'($urandom);
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    req = 2'b00;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
